// File: rtl/tt_um_bnn.sv
// Two-layer binarized neural network (8 inputs, 8 hidden, 8 outputs) built from XNOR-popcount neurons.
// Weights and thresholds are loaded through ui_in/uio_in; a run command yields uo_out two edges later.
module tt_um_bnn (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_LOAD_W = 2'b01,
        CMD_LOAD_T = 2'b10,
        CMD_RUN    = 2'b11
    } cmd_t;

    cmd_t       cmd;
    logic       layerSel;
    logic [2:0] neuronIdx;

    logic [7:0] w1_q [8];
    logic [7:0] w2_q [8];
    logic [3:0] t1_q [8];
    logic [3:0] t2_q [8];
    logic [7:0] hidden_q;
    logic [7:0] hidden_d;
    logic [7:0] out_q;
    logic [7:0] out_d;
    logic       runDly_q;
    logic       unusedInputs;

    assign cmd       = cmd_t'(uio_in[7:6]);
    assign layerSel  = uio_in[3];
    assign neuronIdx = uio_in[2:0];

    // A neuron fires when the number of agreeing bits reaches its threshold.
    function automatic logic neuronFire(input logic [7:0] x, input logic [7:0] w, input logic [3:0] t);
        logic [7:0] agree;
        logic [3:0] count;
        agree = ~(x ^ w);
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, agree[i]};
        end
        return count >= t;
    endfunction

    // Layer 2 reads the registered hidden vector, so a run at the same edge cannot disturb it.
    always_comb begin
        hidden_d = hidden_q;
        out_d    = out_q;
        for (int n = 0; n < 8; n++) begin
            if (cmd == CMD_RUN) begin
                hidden_d[n] = neuronFire(ui_in, w1_q[n], t1_q[n]);
            end
            if (runDly_q) begin
                out_d[n] = neuronFire(hidden_q, w2_q[n], t2_q[n]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 8; n++) begin
                w1_q[n] <= 8'h00;
                w2_q[n] <= 8'h00;
                t1_q[n] <= 4'h0;
                t2_q[n] <= 4'h0;
            end
            hidden_q <= 8'h00;
            out_q    <= 8'h00;
            runDly_q <= 1'b0;
        end else begin
            hidden_q <= hidden_d;
            out_q    <= out_d;
            runDly_q <= (cmd == CMD_RUN);
            if (cmd == CMD_LOAD_W) begin
                if (layerSel) begin
                    w2_q[neuronIdx] <= ui_in;
                end else begin
                    w1_q[neuronIdx] <= ui_in;
                end
            end
            if (cmd == CMD_LOAD_T) begin
                if (layerSel) begin
                    t2_q[neuronIdx] <= ui_in[3:0];
                end else begin
                    t1_q[neuronIdx] <= ui_in[3:0];
                end
            end
        end
    end

    assign uo_out       = out_q;
    assign uio_out      = 8'h00;
    assign uio_oe       = 8'h00;
    assign unusedInputs = &{1'b0, ena, uio_in[5:4]};

endmodule

// File: tb/tb_tt_um_bnn.sv
// Scoreboard bench for tt_um_bnn: directed scenarios plus random traffic against a bit-counting reference model.
// The stimulus side predicts results into a queue; an independent monitor compares them every cycle.
module tb_tt_um_bnn;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_bnn dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] value;
    } expect_t;

    expect_t    expQ[$];
    int         edgeCount = 0;
    int         checks    = 0;
    int         failures  = 0;
    logic [7:0] modelOut  = 8'h00;

    logic [7:0] mW1 [8];
    logic [7:0] mW2 [8];
    int         mT1 [8];
    int         mT2 [8];
    logic       pendingValid = 1'b0;
    logic [7:0] pendingH     = 8'h00;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, edgeCount);
        end
    endtask

    function automatic int agreeCount(input logic [7:0] a, input logic [7:0] b);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] == b[i]) c++;
        end
        return c;
    endfunction

    function automatic logic [7:0] hiddenOf(input logic [7:0] x);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = (agreeCount(x, mW1[n]) >= mT1[n]);
        return r;
    endfunction

    function automatic logic [7:0] outputOf(input logic [7:0] h);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = (agreeCount(h, mW2[n]) >= mT2[n]);
        return r;
    endfunction

    task automatic clearModel();
        for (int n = 0; n < 8; n++) begin
            mW1[n] = 8'h00;
            mW2[n] = 8'h00;
            mT1[n] = 0;
            mT2[n] = 0;
        end
        pendingValid = 1'b0;
        pendingH     = 8'h00;
        expQ.delete();
        modelOut = 8'h00;
    endtask

    // Drives one cycle of input and advances the model to the edge that samples it.
    task automatic applyStimulus(input logic [1:0] cmd, input logic layer, input int idx, input logic [7:0] data);
        expect_t e;
        logic [1:0] junk;
        @(negedge clk);
        junk   = 2'($urandom_range(0, 3));
        ena    = 1'($urandom_range(0, 1));
        ui_in  = data;
        uio_in = {cmd, junk, layer, 3'(idx)};
        if (pendingValid) begin
            e.cyc   = edgeCount + 1;
            e.value = outputOf(pendingH);
            expQ.push_back(e);
        end
        pendingValid = (cmd == 2'b11);
        if (cmd == 2'b11) pendingH = hiddenOf(data);
        if (cmd == 2'b01) begin
            if (layer) mW2[idx] = data;
            else       mW1[idx] = data;
        end
        if (cmd == 2'b10) begin
            if (layer) mT2[idx] = int'(data[3:0]);
            else       mT1[idx] = int'(data[3:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 0, 8'($urandom));
    endtask

    task automatic run(input logic [7:0] x);
        applyStimulus(2'b11, 1'b0, 0, x);
    endtask

    task automatic loadW(input logic layer, input int idx, input logic [7:0] w);
        applyStimulus(2'b01, layer, idx, w);
    endtask

    task automatic loadT(input logic layer, input int idx, input logic [7:0] t);
        applyStimulus(2'b10, layer, idx, t);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        clearModel();
        #1;
        checkOutput("reset_immediate", uo_out, 8'h00);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: retire predictions due at this edge, then compare the held output every cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0 && expQ[0].cyc < edgeCount) begin
            checkOutput("stale_prediction", 8'h00, 8'h01);
            void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].cyc == edgeCount) begin
            modelOut = expQ[0].value;
            void'(expQ.pop_front());
        end
        checkOutput("uo_out", uo_out, modelOut);
        checkOutput("uio_out", uio_out, 8'h00);
        checkOutput("uio_oe", uio_oe, 8'h00);
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        clearModel();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        idle(3);
        checkOutput("idle_after_reset", uo_out, 8'h00);
        run(8'h5A);
        idle(2);
        checkOutput("zero_weights_run", uo_out, 8'hFF);

        for (int n = 0; n < 8; n++) begin
            loadW(1'b0, n, 8'hAA);
            loadT(1'b0, n, 8'h08);
            loadW(1'b1, n, 8'hFF);
            loadT(1'b1, n, 8'h08);
        end
        run(8'hAA);
        idle(2);
        checkOutput("run_AA", uo_out, 8'hFF);
        run(8'hAB);
        idle(2);
        checkOutput("run_AB", uo_out, 8'h00);
        run(8'hAA);
        run(8'hAB);
        run(8'hAA);
        checkOutput("b2b_first", uo_out, 8'hFF);
        idle(1);
        checkOutput("b2b_second", uo_out, 8'h00);
        idle(1);
        checkOutput("b2b_third", uo_out, 8'hFF);

        loadW(1'b0, 0, 8'h0F);
        loadT(1'b0, 0, 8'h06);
        loadW(1'b1, 0, 8'h01);
        loadT(1'b1, 0, 8'h08);
        run(8'h03);
        idle(2);
        checkOutput("thresh_t6_fires", uo_out, 8'h01);
        loadT(1'b0, 0, 8'h07);
        run(8'h03);
        idle(2);
        checkOutput("thresh_t7_quiet", uo_out, 8'h00);

        loadW(1'b0, 1, 8'h3C);
        loadT(1'b0, 1, 8'h09);
        loadW(1'b1, 1, 8'h02);
        loadT(1'b1, 1, 8'h08);
        run(8'h3C);
        idle(2);
        checkOutput("thresh_9_never", uo_out, 8'h00);
        loadT(1'b0, 1, 8'h00);
        run(8'h3C);
        idle(2);
        checkOutput("thresh_0_match", uo_out, 8'h02);
        run(8'h00);
        idle(2);
        checkOutput("thresh_0_x00", {7'b0, uo_out[1]}, 8'h01);
        run(8'h55);
        idle(2);
        checkOutput("thresh_0_x55", {7'b0, uo_out[1]}, 8'h01);

        run(8'h5A);
        doReset();
        idle(3);
        checkOutput("aborted_run", uo_out, 8'h00);
        run(8'h12);
        idle(2);
        checkOutput("run_after_reset", uo_out, 8'hFF);

        idle(10);
        checkOutput("idle_hold", uo_out, 8'hFF);
        for (int n = 0; n < 8; n++) loadT(1'b1, n, 8'h08);
        run(8'h77);
        loadW(1'b1, 0, 8'hFF);
        idle(1);
        checkOutput("old_w2_used", uo_out, 8'h00);
        run(8'h77);
        idle(2);
        checkOutput("new_w2_used", uo_out, 8'h01);

        for (int i = 0; i < 400; i++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 3)      applyStimulus(2'b01, 1'($urandom), int'($urandom_range(0, 7)), 8'($urandom));
            else if (pick < 5) applyStimulus(2'b10, 1'($urandom), int'($urandom_range(0, 7)), 8'($urandom_range(2, 10)));
            else if (pick < 9) run(8'($urandom));
            else               idle(1);
        end
        idle(3);

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drained: %0d predictions left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
